dmem_arbiter: RTL and testbench

//  Shares the single data-RAM port between the CPU load/store path (port C) and a debug/loader

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 21 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way picker between CPU (C) and debug (D) requesters
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_grant_i,
    input  logic       mode_i,
    output owner_t     winner_o
);

    // req_i[0] is C, req_i[1] is D; a tie in fixed mode always goes to C
    always_comb begin
        winner_o = OWN_C;
        if (req_i == 2'b10) begin
            winner_o = OWN_D;
        end else if (req_i == 2'b11 && !mode_i && last_grant_i == OWN_C) begin
            winner_o = OWN_D;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-RAM port between CPU load/store and debug loader
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [DW-1:0] c_wdata_i,
    input  logic          c_addrSelect_i,
    output logic          c_ack_o,
    output logic          c_rvalid_o,
    output logic [DW-1:0] c_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    input  logic          d_addrSelect_i,
    output logic          d_ack_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wdata_o,
    output logic          m_addrSelect_o,
    input  logic [DW-1:0] m_rdata_i,
    output logic          stall_o
);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        last_q, last_d;
    owner_t        winner;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          asel_q, asel_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          in_access, in_resp;

    rr_arb2 u_pick (
        .req_i        ({d_req_i, c_req_i}),
        .last_grant_i (last_q),
        .mode_i       (ARB_MODE == ARB_FIXED),
        .winner_o     (winner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asel_d    = asel_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (c_req_i || d_req_i) begin
                    owner_d = winner;
                    last_d  = winner;
                    state_d = ACCESS;
                    if (winner == OWN_C) begin
                        we_d    = c_we_i;
                        addr_d  = c_addr_i;
                        wdata_d = c_wdata_i;
                        asel_d  = c_addrSelect_i;
                    end else begin
                        we_d    = d_we_i;
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                        asel_d  = d_addrSelect_i;
                    end
                end
            end
            ACCESS: state_d = we_q ? IDLE : RESP;
            RESP: begin
                state_d = IDLE;
                if (owner_q == OWN_C) c_rdata_d = m_rdata_i;
                else                  d_rdata_d = m_rdata_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_C;
            last_q    <= OWN_D;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            asel_q    <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            asel_q    <= asel_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Reset masks strobes so a reset edge never commits a write or reports stale read data
    assign in_access = (state_q == ACCESS) && !rst;
    assign in_resp   = (state_q == RESP) && !rst;

    assign c_ack_o    = in_access && (owner_q == OWN_C);
    assign d_ack_o    = in_access && (owner_q == OWN_D);
    assign c_rvalid_o = in_resp && (owner_q == OWN_C);
    assign d_rvalid_o = in_resp && (owner_q == OWN_D);
    assign c_rdata_o  = c_rvalid_o ? m_rdata_i : c_rdata_q;
    assign d_rdata_o  = d_rvalid_o ? m_rdata_i : d_rdata_q;

    assign m_we_o         = in_access && we_q;
    assign m_addr_o       = addr_q;
    assign m_wdata_o      = wdata_q;
    assign m_addrSelect_o = asel_q;
    assign stall_o        = c_req_i && !c_ack_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (round-robin and fixed-priority)
module tb_dmem_arbiter;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_asel, c_ack, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_asel, d_ack, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_we, m_asel, stall;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic        c1_req, d1_req, c1_ack, d1_ack, c1_rvalid, d1_rvalid;
    logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata;
    logic        m1_we, m1_asel, stall1;

    logic [31:0] mem [0:63];
    bit          mem_first = 1'b1;

    exp_t ack_q[$];
    exp_t rd_q[$];
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DW(32), .AW(32), .ARB_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
        .c_addrSelect_i(c_asel), .c_ack_o(c_ack), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_addrSelect_i(d_asel), .d_ack_o(d_ack), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_addrSelect_o(m_asel),
        .m_rdata_i(m_rdata), .stall_o(stall)
    );

    dmem_arbiter #(.DW(32), .AW(32), .ARB_MODE(1)) dut_fixed (
        .clk(clk), .rst(rst),
        .c_req_i(c1_req), .c_we_i(1'b1), .c_addr_i(32'h100), .c_wdata_i(32'h1),
        .c_addrSelect_i(1'b0), .c_ack_o(c1_ack), .c_rvalid_o(c1_rvalid), .c_rdata_o(c1_rdata),
        .d_req_i(d1_req), .d_we_i(1'b1), .d_addr_i(32'h104), .d_wdata_i(32'h2),
        .d_addrSelect_i(1'b0), .d_ack_o(d1_ack), .d_rvalid_o(d1_rvalid), .d_rdata_o(d1_rdata),
        .m_we_o(m1_we), .m_addr_o(m1_addr), .m_wdata_o(m1_wdata), .m_addrSelect_o(m1_asel),
        .m_rdata_i(32'h0), .stall_o(stall1)
    );

    // RAM model: synchronous read, data valid the cycle after the address
    always @(posedge clk) begin
        if (mem_first) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | i;
            mem_first <= 1'b0;
        end else if (m_we) begin
            mem[m_addr[7:2]] <= m_wdata;
        end
        m_rdata <= mem[m_addr[7:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (c_ack && d_ack) chk("dual_ack", 32'(d_ack), 32'h0);
                if (c_ack || d_ack) begin
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", 32'(d_ack), 32'(~d_ack));
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_port", 32'(d_ack), 32'(e.port));
                        chk("ack_we", 32'(m_we), 32'(e.we));
                        chk("ack_addr", m_addr, e.addr);
                        if (e.we) chk("ack_wdata", m_wdata, e.data);
                    end
                end
                if (c_rvalid || d_rvalid) begin
                    if (rd_q.size() == 0) begin
                        chk("unexpected_rvalid", 32'(d_rvalid), 32'(~d_rvalid));
                    end else begin
                        e = rd_q.pop_front();
                        chk("rv_port", 32'(d_rvalid), 32'(e.port));
                        chk("rv_data", e.port ? d_rdata : c_rdata, e.data);
                    end
                end
            end
        end
    endtask

    // For writes data is the write value; for reads it is the expected read value
    task automatic txn(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] data);
        int n;
        @(posedge clk); #1;
        if (!port) begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = data;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = data;
        end
        ack_q.push_back('{port, we, addr, data});
        if (!we) rd_q.push_back('{port, we, addr, data});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && !port) chk("stall_wait", 32'(stall), 32'h1);
        end while (!(port ? d_ack : c_ack) && n < 20);
        chk("ack_lat", n, 2);
        if (!port) chk("stall_ack", 32'(stall), 32'h0);
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
        if (!we) begin
            @(negedge clk);
            chk("rv_lat", 32'(port ? d_rvalid : c_rvalid), 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   n, na_c, na_d, ci, di;
        logic got_d;
        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_asel = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_asel = 0;
        c1_req = 0; d1_req = 0;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_strobes", {26'b0, c_ack, d_ack, c_rvalid, d_rvalid, m_we, stall}, 32'h0);
        chk("reset_addr", m_addr, 32'h0);
        chk("reset_wdata", m_wdata, 32'h0);
        chk("reset_c_rdata", c_rdata, 32'h0);

        // 1/2: single-port write then read-back
        txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rdata_hold", c_rdata, 32'hDEAD_BEEF);
        chk("d_idle", {30'b0, d_ack, d_rvalid}, 32'h0);

        // 3: both requesting continuously, round-robin from reset (C first)
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ack_q.push_back('{1'b0, 1'b1, 32'h40 + 8 * k, 32'hC000_0000 + k});
            ack_q.push_back('{1'b1, 1'b1, 32'h44 + 8 * k, 32'hD000_0000 + k});
        end
        ci = 0; di = 0;
        c_req = 1; c_we = 1; c_addr = 32'h40; c_wdata = 32'hC000_0000;
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hD000_0000;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(c_ack || d_ack) && n < 20);
            chk("rr_lat", n, 2);
            got_d = d_ack;
            @(posedge clk); #1;
            if (got_d) begin
                di++; d_addr = 32'h44 + 8 * di; d_wdata = 32'hD000_0000 + di;
            end else begin
                ci++; c_addr = 32'h40 + 8 * ci; c_wdata = 32'hC000_0000 + ci;
            end
        end
        c_req = 0; d_req = 0;
        txn(1'b0, 1'b0, 32'h48, 32'hC000_0001);
        txn(1'b1, 1'b0, 32'h44, 32'hD000_0000);

        // 4: fixed priority, C held for ten cycles then dropped
        @(posedge clk); #1;
        c1_req = 1; d1_req = 1; na_c = 0; na_d = 0;
        repeat (10) begin
            @(negedge clk);
            na_c += int'(c1_ack);
            na_d += int'(d1_ack);
        end
        chk("fixed_c_acks", na_c, 5);
        chk("fixed_d_acks", na_d, 0);
        @(posedge clk); #1 c1_req = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d1_ack && n < 20);
        chk("fixed_d_lat", n, 2);
        @(posedge clk); #1 d1_req = 0;

        // 5: reset during the response cycle of a D read
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 32'h20;
        ack_q.push_back('{1'b1, 1'b0, 32'h20, 32'h0});
        @(negedge clk);
        @(negedge clk);
        chk("t5_ack", 32'(d_ack), 32'h1);
        @(posedge clk); #1;
        d_req = 0; rst = 1'b1;
        @(negedge clk);
        chk("t5_rv_in_rst", 32'(d_rvalid), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_strobes", {26'b0, c_ack, d_ack, c_rvalid, d_rvalid, m_we, stall}, 32'h0);
        chk("t5_addr", m_addr, 32'h0);
        chk("t5_d_rdata", d_rdata, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_rv", 32'(d_rvalid), 32'h0);
        end

        // 6: reset during ACCESS of a D write must not commit it
        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h1234;
        @(posedge clk); #1;
        rst = 1'b1; d_req = 0;
        @(negedge clk);
        chk("t6_we_gated", 32'(m_we), 32'h0);
        chk("t6_ack_gated", 32'(d_ack), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        txn(1'b0, 1'b0, 32'h30, 32'hA000_000C);

        // C write whose fields change after grant: latched address/data must be used
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_addr = 32'h30; c_wdata = 32'h5555;
        ack_q.push_back('{1'b0, 1'b1, 32'h30, 32'h5555});
        @(posedge clk); #1;
        c_addr = 32'h34; c_wdata = 32'hBAD;
        @(negedge clk);
        chk("t6_c_ack", 32'(c_ack), 32'h1);
        @(posedge clk); #1 c_req = 0;
        txn(1'b0, 1'b0, 32'h30, 32'h5555);
        txn(1'b1, 1'b0, 32'h34, 32'hA000_000D);

        repeat (3) @(negedge clk);
        chk("ack_q_drained", ack_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
